// File: rtl/toggle_cover_scheduler.sv
// Toggle-coverage hit serialiser: captures first hits per epoch and reports one
// cover index per valid/ready handshake, round-robin over pending bits.
module toggle_cover_scheduler #(
  parameter int unsigned     WIDTH       = 36,
  parameter longint unsigned COVER_INDEX = 0,
  parameter longint unsigned COVER_TOTAL = 38253
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] valid_i,
  input  logic             clear_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [63:0]      out_index_o,
  output logic [15:0]      reported_count_o,
  output logic             all_seen_o,
  output logic             busy_o
);

  localparam int unsigned      PTR_W = $clog2(WIDTH);
  localparam int unsigned      IDX_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("toggle_cover_scheduler: WIDTH must be in 2..64");
  end
  if (COVER_INDEX + longint'(WIDTH) > COVER_TOTAL) begin : g_bad_range
    $error("toggle_cover_scheduler: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0] seen_q, seen_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_index_q, out_index_d;
  logic [15:0]      count_q, count_d;

  logic             found;
  logic [PTR_W-1:0] sel;
  logic [IDX_W-1:0] idx;
  logic             load;
  logic             grant;

  // Round-robin search from rr_ptr over the registered pending vector only.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      idx = {1'b0, rr_ptr_q} + IDX_W'(i);
      if (idx >= IDX_W'(WIDTH)) begin
        idx = idx - IDX_W'(WIDTH);
      end
      if (!found && pending_q[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        sel   = idx[PTR_W-1:0];
      end
    end
  end

  assign load  = !out_valid_q || out_ready_i;
  assign grant = load && found;

  always_comb begin
    seen_d      = seen_q | valid_i;
    pending_d   = pending_q | (valid_i & ~seen_q);
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    count_d     = count_q;

    if (grant) begin
      pending_d[sel] = 1'b0;
      rr_ptr_d       = (sel == LAST) ? '0 : sel + PTR_W'(1);
    end

    if (load) begin
      out_valid_d = found;
      if (found) begin
        out_index_d = COVER_INDEX + 64'(sel);
      end
    end

    // A new epoch overrides both capture and the removal of a granted bit.
    if (clear_i) begin
      seen_d    = valid_i;
      pending_d = valid_i;
      rr_ptr_d  = '0;
    end

    if (out_valid_q && out_ready_i && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      seen_q      <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      count_q     <= '0;
    end else begin
      seen_q      <= seen_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
      count_q     <= count_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_index_o      = out_index_q;
  assign reported_count_o = count_q;
  assign all_seen_o       = &seen_q;
  assign busy_o           = (|pending_q) || out_valid_q;

endmodule
